// File: rtl/load_queue.sv
// Circular in-order load queue: captures operands (direct or CDB snoop), one outstanding word read, CDB retire.
// Optional LQ_MISALIGN_CHK_EN: misaligned LH/LHU/LW bypass memory and retire with an exception flag.
module load_queue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 5,
  parameter int XLEN  = 32
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       flush,
  input  logic                       alloc_valid,
  output logic                       alloc_ready,
  input  logic [XLEN-1:0]            alloc_v1,
  input  logic                       alloc_v1_valid,
  input  logic [TAG_W-1:0]           alloc_q1,
  input  logic [XLEN-1:0]            alloc_v2,
  input  logic                       alloc_v2_valid,
  input  logic [TAG_W-1:0]           alloc_q2,
  input  logic [TAG_W-1:0]           alloc_rd_tag,
  input  logic [2:0]                 alloc_funct3,
  input  logic                       cdb_in_valid,
  input  logic [TAG_W-1:0]           cdb_in_tag,
  input  logic [XLEN-1:0]            cdb_in_val,
  output logic                       mem_req_valid,
  input  logic                       mem_req_ready,
  output logic [XLEN-1:0]            mem_addr,
  input  logic                       mem_resp_valid,
  input  logic [XLEN-1:0]            mem_resp_data,
  output logic                       cdb_req,
  input  logic                       cdb_grant,
  output logic [XLEN-1:0]            cdb_out_val,
  output logic [TAG_W-1:0]           cdb_out_tag,
  output logic                       cdb_out_exc,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {S_EMPTY, S_WAIT, S_READY, S_ISSUED, S_DONE} state_t;

  state_t           r_state [DEPTH];
  state_t           w_state_nxt [DEPTH];
  logic [XLEN-1:0]  r_v1 [DEPTH];
  logic [XLEN-1:0]  r_v2 [DEPTH];
  logic [XLEN-1:0]  r_res [DEPTH];
  logic             r_v1_vld [DEPTH];
  logic             r_v2_vld [DEPTH];
  logic [TAG_W-1:0] r_q1 [DEPTH];
  logic [TAG_W-1:0] r_q2 [DEPTH];
  logic [TAG_W-1:0] r_tag [DEPTH];
  logic [2:0]       r_f3 [DEPTH];
  logic             w_snoop1 [DEPTH];
  logic             w_snoop2 [DEPTH];
  logic [PW-1:0]    r_head, r_issue, r_tail;
  logic [CW-1:0]    r_count;
  logic             r_drop;

  logic             w_alloc, w_retire, w_a1_vld, w_a2_vld, w_iss_rdy, w_mis;
  logic             w_req_fire, w_skip, w_resp;
  logic [XLEN-1:0]  w_a1_val, w_a2_val, w_iss_addr, w_load;

  function automatic logic [XLEN-1:0] extract(input logic [XLEN-1:0] word, input logic [1:0] off,
                                              input logic [2:0] f3);
    logic [XLEN-1:0] sh;
    sh = word >> {off, 3'b000};
    case (f3)
      3'b000:  extract = {{(XLEN-8){sh[7]}}, sh[7:0]};
      3'b100:  extract = {{(XLEN-8){1'b0}}, sh[7:0]};
      3'b001:  extract = {{(XLEN-16){sh[15]}}, sh[15:0]};
      3'b101:  extract = {{(XLEN-16){1'b0}}, sh[15:0]};
      default: extract = sh;
    endcase
  endfunction

  assign w_alloc    = alloc_valid && alloc_ready && !flush;
  assign w_retire   = cdb_req && cdb_grant;
  assign w_a1_vld   = alloc_v1_valid || (cdb_in_valid && cdb_in_tag == alloc_q1);
  assign w_a2_vld   = alloc_v2_valid || (cdb_in_valid && cdb_in_tag == alloc_q2);
  assign w_a1_val   = alloc_v1_valid ? alloc_v1 : cdb_in_val;
  assign w_a2_val   = alloc_v2_valid ? alloc_v2 : cdb_in_val;
  assign w_iss_addr = r_v1[r_issue] + r_v2[r_issue];
  assign w_iss_rdy  = (r_state[r_issue] == S_READY);
`ifdef LQ_MISALIGN_CHK_EN
  assign w_mis = ((r_f3[r_issue][1:0] == 2'b01) && w_iss_addr[0]) ||
                 ((r_f3[r_issue][1:0] == 2'b10) && (w_iss_addr[1:0] != 2'b00));
`else
  assign w_mis = 1'b0;
`endif
  // Only one request in flight: the issue pointer stays on an entry until its response lands.
  assign mem_req_valid = w_iss_rdy && !w_mis && !r_drop;
  assign w_req_fire    = mem_req_valid && mem_req_ready;
  assign w_skip        = w_iss_rdy && w_mis;
  assign w_resp        = mem_resp_valid && (r_state[r_issue] == S_ISSUED) && !r_drop;
  assign w_load        = extract(mem_resp_data, w_iss_addr[1:0], r_f3[r_issue]);
  assign mem_addr      = mem_req_valid ? {w_iss_addr[XLEN-1:2], 2'b00} : '0;

  assign cdb_req     = (r_state[r_head] == S_DONE);
  assign cdb_out_val = cdb_req ? r_res[r_head] : '0;
  assign cdb_out_tag = cdb_req ? r_tag[r_head] : '0;
  assign alloc_ready = (r_count != CW'(DEPTH));
  assign count       = r_count;

  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      w_snoop1[e] = cdb_in_valid && (r_state[e] == S_WAIT) && !r_v1_vld[e] && (r_q1[e] == cdb_in_tag);
      w_snoop2[e] = cdb_in_valid && (r_state[e] == S_WAIT) && !r_v2_vld[e] && (r_q2[e] == cdb_in_tag);
    end
  end

  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      w_state_nxt[e] = r_state[e];
      case (r_state[e])
        S_EMPTY:  if (w_alloc && r_tail == PW'(e))
                    w_state_nxt[e] = (w_a1_vld && w_a2_vld) ? S_READY : S_WAIT;
        S_WAIT:   if ((r_v1_vld[e] || w_snoop1[e]) && (r_v2_vld[e] || w_snoop2[e]))
                    w_state_nxt[e] = S_READY;
        S_READY:  if (r_issue == PW'(e)) begin
                    if (w_skip)          w_state_nxt[e] = S_DONE;
                    else if (w_req_fire) w_state_nxt[e] = S_ISSUED;
                  end
        S_ISSUED: if (w_resp && r_issue == PW'(e)) w_state_nxt[e] = S_DONE;
        S_DONE:   if (w_retire && r_head == PW'(e)) w_state_nxt[e] = S_EMPTY;
        default:  w_state_nxt[e] = S_EMPTY;
      endcase
      if (flush) w_state_nxt[e] = S_EMPTY;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int e = 0; e < DEPTH; e++) r_state[e] <= S_EMPTY;
    end else begin
      for (int e = 0; e < DEPTH; e++) r_state[e] <= w_state_nxt[e];
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_head  <= '0;
      r_issue <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_drop  <= 1'b0;
    end else if (flush) begin
      r_head  <= '0;
      r_issue <= '0;
      r_tail  <= '0;
      r_count <= '0;
      // A read still in flight (or launched this very cycle) must have its data swallowed later.
      r_drop  <= ((r_state[r_issue] == S_ISSUED) && !mem_resp_valid) || w_req_fire ||
                 (r_drop && !mem_resp_valid);
    end else begin
      if (w_alloc)           r_tail  <= r_tail + 1'b1;
      if (w_retire)          r_head  <= r_head + 1'b1;
      if (w_resp || w_skip)  r_issue <= r_issue + 1'b1;
      r_count <= r_count + CW'(w_alloc) - CW'(w_retire);
      if (r_drop && mem_resp_valid) r_drop <= 1'b0;
    end
  end

`ifdef LQ_MISALIGN_CHK_EN
  logic r_exc [DEPTH];
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int e = 0; e < DEPTH; e++) r_exc[e] <= 1'b0;
    end else begin
      if (w_resp) r_exc[r_issue] <= 1'b0;
      if (w_skip) r_exc[r_issue] <= 1'b1;
    end
  end
  assign cdb_out_exc = cdb_req && r_exc[r_head];
`else
  assign cdb_out_exc = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int e = 0; e < DEPTH; e++) begin
        r_v1[e]     <= '0;
        r_v2[e]     <= '0;
        r_res[e]    <= '0;
        r_v1_vld[e] <= 1'b0;
        r_v2_vld[e] <= 1'b0;
        r_q1[e]     <= '0;
        r_q2[e]     <= '0;
        r_tag[e]    <= '0;
        r_f3[e]     <= '0;
      end
    end else begin
      for (int e = 0; e < DEPTH; e++) begin
        if (w_snoop1[e]) begin
          r_v1[e]     <= cdb_in_val;
          r_v1_vld[e] <= 1'b1;
        end
        if (w_snoop2[e]) begin
          r_v2[e]     <= cdb_in_val;
          r_v2_vld[e] <= 1'b1;
        end
      end
      if (w_alloc) begin
        r_v1[r_tail]     <= w_a1_val;
        r_v2[r_tail]     <= w_a2_val;
        r_v1_vld[r_tail] <= w_a1_vld;
        r_v2_vld[r_tail] <= w_a2_vld;
        r_q1[r_tail]     <= alloc_q1;
        r_q2[r_tail]     <= alloc_q2;
        r_tag[r_tail]    <= alloc_rd_tag;
        r_f3[r_tail]     <= alloc_funct3;
      end
      if (w_resp) r_res[r_issue] <= w_load;
      if (w_skip) r_res[r_issue] <= '0;
    end
  end
endmodule

// File: tb/tb_load_queue.sv
// Bench for load_queue: directed vector table, multi-cycle corner sequences, randomized run vs. queue model.
module tb_load_queue;
  localparam int DEPTH = 4;

  logic        CLK, RST, flush, alloc_valid, alloc_ready;
  logic [31:0] alloc_v1, alloc_v2, cdb_in_val, mem_addr, mem_resp_data, cdb_out_val;
  logic        alloc_v1_valid, alloc_v2_valid, cdb_in_valid, mem_req_valid, mem_req_ready;
  logic [4:0]  alloc_q1, alloc_q2, alloc_rd_tag, cdb_in_tag, cdb_out_tag;
  logic [2:0]  alloc_funct3, count;
  logic        mem_resp_valid, cdb_req, cdb_grant, cdb_out_exc;

  load_queue #(.DEPTH(DEPTH), .TAG_W(5), .XLEN(32)) dut (
    .CLK(CLK), .RST(RST), .flush(flush), .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_v1(alloc_v1), .alloc_v1_valid(alloc_v1_valid), .alloc_q1(alloc_q1),
    .alloc_v2(alloc_v2), .alloc_v2_valid(alloc_v2_valid), .alloc_q2(alloc_q2),
    .alloc_rd_tag(alloc_rd_tag), .alloc_funct3(alloc_funct3),
    .cdb_in_valid(cdb_in_valid), .cdb_in_tag(cdb_in_tag), .cdb_in_val(cdb_in_val),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .cdb_req(cdb_req), .cdb_grant(cdb_grant), .cdb_out_val(cdb_out_val),
    .cdb_out_tag(cdb_out_tag), .cdb_out_exc(cdb_out_exc), .count(count)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1);
  end

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] v1, v2, word;
    logic [4:0]  tag;
    logic [31:0] exp_addr, exp_val;
  } vec_t;

  typedef struct {
    logic [4:0]  tag;
    logic [31:0] val;
    logic        exc;
  } res_t;

  vec_t        vecs [10];
  res_t        res_q [$];
  logic [31:0] addr_q [$];

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic idle();
    flush = 0; alloc_valid = 0; alloc_v1 = 0; alloc_v1_valid = 0; alloc_q1 = 0;
    alloc_v2 = 0; alloc_v2_valid = 0; alloc_q2 = 0; alloc_rd_tag = 0; alloc_funct3 = 0;
    cdb_in_valid = 0; cdb_in_tag = 0; cdb_in_val = 0; mem_req_ready = 0;
    mem_resp_valid = 0; mem_resp_data = 0; cdb_grant = 0;
  endtask

  task automatic alloc_ld(input logic [2:0] f3, input logic [31:0] v1, input logic v1v, input logic [4:0] q1,
                          input logic [31:0] v2, input logic v2v, input logic [4:0] q2, input logic [4:0] tag);
    alloc_valid = 1; alloc_funct3 = f3; alloc_rd_tag = tag;
    alloc_v1 = v1; alloc_v1_valid = v1v; alloc_q1 = q1;
    alloc_v2 = v2; alloc_v2_valid = v2v; alloc_q2 = q2;
  endtask

  // Entered in the cycle a request is expected; checks exact request->response->broadcast timing.
  task automatic serve(input string nm, input logic [31:0] word, input logic [4:0] tag, input logic [31:0] expv);
    chk({nm, " req_vld"}, 32'(mem_req_valid), 32'd1);
    mem_req_ready = 1;
    step();
    mem_req_ready = 0;
    mem_resp_valid = 1;
    mem_resp_data = word;
    step();
    mem_resp_valid = 0;
    chk({nm, " cdb_req"}, 32'(cdb_req), 32'd1);
    chk({nm, " val"}, cdb_out_val, expv);
    chk({nm, " tag"}, 32'(cdb_out_tag), 32'(tag));
    chk({nm, " exc"}, 32'(cdb_out_exc), 32'd0);
    cdb_grant = 1;
    step();
    cdb_grant = 0;
  endtask

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  // Reference: pick n bytes starting at the byte offset, bytes past the word read as zero, then extend.
  function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [1:0] off,
                                           input logic [2:0] f3, output logic exc);
    logic [7:0]  b [4];
    logic [31:0] v;
    int          n, o;
    for (int k = 0; k < 4; k++) b[k] = word[8*k +: 8];
    n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    o = int'(off);
    exc = 1'b0;
`ifdef LQ_MISALIGN_CHK_EN
    if ((n == 2 && off[0]) || (n == 4 && off != 2'b00)) begin
      exc = 1'b1;
      return 32'd0;
    end
`endif
    v = 0;
    for (int k = 0; k < n; k++)
      if (o + k < 4) v = v | (32'(b[o + k]) << (8 * k));
    if (!f3[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  logic [31:0] t1, t2, ra, rv, pend_val, rsp_addr;
  logic [2:0]  rf3;
  logic [2:0]  f3_tab [5];
  logic [4:0]  rtag, pend_tag;
  logic        v1v, v2v, re, gen, pend_active, rsp_active;
  int          pend_cnt, rsp_cnt;
  res_t        er;

  initial begin
    vecs[0] = '{3'b010, 32'h100,      32'h4, 32'hDEADBEEF, 5'd1,  32'h104,  32'hDEADBEEF};
    vecs[1] = '{3'b000, 32'h200,      32'h3, 32'h80FFFFFF, 5'd2,  32'h200,  32'hFFFFFF80};
    vecs[2] = '{3'b100, 32'h200,      32'h3, 32'h80FFFFFF, 5'd3,  32'h200,  32'h00000080};
    vecs[3] = '{3'b101, 32'h200,      32'h2, 32'hBEEF1234, 5'd4,  32'h200,  32'h0000BEEF};
    vecs[4] = '{3'b001, 32'h1000,     32'h2, 32'h80017FFF, 5'd5,  32'h1000, 32'hFFFF8001};
    vecs[5] = '{3'b000, 32'h10,       32'h1, 32'h12345678, 5'd6,  32'h10,   32'h00000056};
    vecs[6] = '{3'b010, 32'hFFFFFFFC, 32'h8, 32'hCAFEF00D, 5'd7,  32'h4,    32'hCAFEF00D};
    vecs[7] = '{3'b001, 32'h0,        32'h0, 32'h0000ABCD, 5'd8,  32'h0,    32'hFFFFABCD};
    vecs[8] = '{3'b100, 32'h30,       32'h2, 32'h00FE0000, 5'd9,  32'h30,   32'h000000FE};
    vecs[9] = '{3'b101, 32'h40,       32'h0, 32'h1234F00D, 5'd31, 32'h40,   32'h0000F00D};
    f3_tab[0] = 3'b000; f3_tab[1] = 3'b001; f3_tab[2] = 3'b010; f3_tab[3] = 3'b100; f3_tab[4] = 3'b101;

    idle();
    RST = 1;
    step();
    chk("rst alloc_ready", 32'(alloc_ready), 32'd1);
    chk("rst count", 32'(count), 32'd0);
    chk("rst mem_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst mem_addr", mem_addr, 32'd0);
    chk("rst cdb_req", 32'(cdb_req), 32'd0);
    chk("rst cdb_out_val", cdb_out_val, 32'd0);
    chk("rst cdb_out_tag", 32'(cdb_out_tag), 32'd0);
    chk("rst cdb_out_exc", 32'(cdb_out_exc), 32'd0);
    step();
    RST = 0;
    step();

    for (int i = 0; i < 10; i++) begin
      alloc_ld(vecs[i].f3, vecs[i].v1, 1, 0, vecs[i].v2, 1, 0, vecs[i].tag);
      step();
      alloc_valid = 0;
      chk($sformatf("vec%0d addr", i), mem_addr, vecs[i].exp_addr);
      serve($sformatf("vec%0d", i), vecs[i].word, vecs[i].tag, vecs[i].exp_val);
      chk($sformatf("vec%0d count", i), 32'(count), 32'd0);
    end

    // Base operand arrives from the CDB two cycles after dispatch; tag 7 must not disturb valid v2.
    alloc_ld(3'b010, 32'h0, 0, 5'd7, 32'h8, 1, 5'd7, 5'd3);
    step();
    alloc_valid = 0;
    chk("snoop wait1 req", 32'(mem_req_valid), 32'd0);
    step();
    chk("snoop wait2 req", 32'(mem_req_valid), 32'd0);
    cdb_in_valid = 1; cdb_in_tag = 5'd7; cdb_in_val = 32'h40;
    step();
    cdb_in_valid = 0;
    chk("snoop addr", mem_addr, 32'h48);
    serve("snoop", 32'h11223344, 5'd3, 32'h11223344);

    // Producer broadcasts in the same cycle as dispatch.
    alloc_ld(3'b010, 32'h300, 1, 5'd0, 32'h0, 0, 5'd9, 5'd12);
    cdb_in_valid = 1; cdb_in_tag = 5'd9; cdb_in_val = 32'h4;
    step();
    alloc_valid = 0; cdb_in_valid = 0;
    chk("samecyc addr", mem_addr, 32'h304);
    serve("samecyc", 32'h55AA55AA, 5'd12, 32'h55AA55AA);

    // Fill with memory stalled, then drain in order; alloc offered while full and retiring.
    for (int i = 0; i < 4; i++) begin
      alloc_ld(3'b010, 32'h400 + 32'(16 * i), 1, 0, 32'h0, 1, 0, 5'(10 + i));
      step();
    end
    alloc_valid = 0;
    chk("full count", 32'(count), 32'd4);
    chk("full alloc_ready", 32'(alloc_ready), 32'd0);
    alloc_ld(3'b010, 32'h800, 1, 0, 32'h0, 1, 0, 5'd30);
    step();
    alloc_valid = 0;
    chk("full alloc ignored", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("fill%0d req", i), 32'(mem_req_valid), 32'd1);
      chk($sformatf("fill%0d addr", i), mem_addr, 32'h400 + 32'(16 * i));
      mem_req_ready = 1;
      step();
      mem_req_ready = 0;
      mem_resp_valid = 1;
      mem_resp_data = 32'hA000_0000 + 32'(i);
      step();
      mem_resp_valid = 0;
      chk($sformatf("fill%0d cdb_req", i), 32'(cdb_req), 32'd1);
      chk($sformatf("fill%0d tag", i), 32'(cdb_out_tag), 32'(10 + i));
      chk($sformatf("fill%0d val", i), cdb_out_val, 32'hA000_0000 + 32'(i));
      cdb_grant = 1;
      if (i == 0) begin
        alloc_ld(3'b010, 32'h900, 1, 0, 32'h0, 1, 0, 5'd31);
        chk("full retire no bypass", 32'(alloc_ready), 32'd0);
      end
      step();
      cdb_grant = 0;
      alloc_valid = 0;
      chk($sformatf("fill%0d count", i), 32'(count), 32'(3 - i));
    end

    // Flush with one read outstanding: late data must vanish, following load issues after it.
    alloc_ld(3'b010, 32'h500, 1, 0, 32'h0, 1, 0, 5'd20);
    step();
    alloc_valid = 0;
    chk("flush A req", 32'(mem_req_valid), 32'd1);
    mem_req_ready = 1;
    step();
    mem_req_ready = 0;
    alloc_ld(3'b010, 32'h600, 1, 0, 32'h0, 1, 0, 5'd21);
    step();
    alloc_valid = 0;
    flush = 1;
    step();
    flush = 0;
    chk("flush count", 32'(count), 32'd0);
    chk("flush cdb_req", 32'(cdb_req), 32'd0);
    chk("flush req", 32'(mem_req_valid), 32'd0);
    alloc_ld(3'b010, 32'h700, 1, 0, 32'h0, 1, 0, 5'd22);
    step();
    alloc_valid = 0;
    chk("drop blocks issue", 32'(mem_req_valid), 32'd0);
    mem_resp_valid = 1;
    mem_resp_data = 32'hBAD0BAD0;
    step();
    mem_resp_valid = 0;
    chk("late resp dropped", 32'(cdb_req), 32'd0);
    chk("post flush addr", mem_addr, 32'h700);
    serve("post flush", 32'h77777777, 5'd22, 32'h77777777);

    mem_resp_valid = 1;
    mem_resp_data = 32'h12341234;
    step();
    mem_resp_valid = 0;
    chk("stray resp cdb_req", 32'(cdb_req), 32'd0);
    chk("stray resp count", 32'(count), 32'd0);

`ifdef LQ_MISALIGN_CHK_EN
    alloc_ld(3'b010, 32'h100, 1, 0, 32'h2, 1, 0, 5'd14);
    step();
    alloc_valid = 0;
    chk("mis LW req", 32'(mem_req_valid), 32'd0);
    step();
    chk("mis LW cdb_req", 32'(cdb_req), 32'd1);
    chk("mis LW exc", 32'(cdb_out_exc), 32'd1);
    chk("mis LW val", cdb_out_val, 32'd0);
    chk("mis LW tag", 32'(cdb_out_tag), 32'd14);
    cdb_grant = 1;
    step();
    cdb_grant = 0;
`else
    alloc_ld(3'b010, 32'h100, 1, 0, 32'h2, 1, 0, 5'd14);
    step();
    alloc_valid = 0;
    chk("mis LW addr", mem_addr, 32'h100);
    serve("mis LW", 32'hDEADBEEF, 5'd14, 32'h0000DEAD);
    alloc_ld(3'b001, 32'h103, 1, 0, 32'h0, 1, 0, 5'd15);
    step();
    alloc_valid = 0;
    chk("mis LH addr", mem_addr, 32'h100);
    serve("mis LH", 32'hAB123456, 5'd15, 32'h000000AB);
`endif

    // Randomized traffic against an in-order queue model.
    pend_active = 0; rsp_active = 0; pend_cnt = 0; rsp_cnt = 0;
    pend_tag = 0; pend_val = 0; rsp_addr = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      step();
      idle();
      gen = (cyc < 2500);
      chk("rand count", 32'(count), 32'(res_q.size()));
      chk("rand alloc_ready", 32'(alloc_ready), 32'(res_q.size() < DEPTH));
      if (gen && $urandom_range(0, 99) < 55) begin
        rf3 = f3_tab[$urandom_range(0, 4)];
        t1 = $urandom;
        t2 = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 15));
        rtag = 5'($urandom);
        v1v = 1; v2v = 1;
        if (alloc_ready && !pend_active && $urandom_range(0, 99) < 35) begin
          pend_active = 1;
          pend_tag = 5'($urandom);
          pend_cnt = $urandom_range(0, 3);
          if ($urandom_range(0, 1) == 1) begin v1v = 0; pend_val = t1; end
          else begin v2v = 0; pend_val = t2; end
        end
        alloc_ld(rf3, v1v ? t1 : $urandom, v1v, v1v ? 5'($urandom) : pend_tag,
                 v2v ? t2 : $urandom, v2v, v2v ? 5'($urandom) : pend_tag, rtag);
      end
      if (pend_active) begin
        if (pend_cnt == 0) begin
          cdb_in_valid = 1; cdb_in_tag = pend_tag; cdb_in_val = pend_val;
          pend_active = 0;
        end else pend_cnt--;
      end
      mem_req_ready = 1'($urandom_range(0, 1));
      if (rsp_active) begin
        if (rsp_cnt == 0) begin
          mem_resp_valid = 1; mem_resp_data = memfn(rsp_addr);
          rsp_active = 0;
        end else rsp_cnt--;
      end
      cdb_grant = ($urandom_range(0, 99) < 60);
      @(negedge CLK);
      if (alloc_valid && alloc_ready) begin
        ra = t1 + t2;
        rv = ref_load(memfn({ra[31:2], 2'b00}), ra[1:0], rf3, re);
        if (!re) addr_q.push_back({ra[31:2], 2'b00});
        res_q.push_back('{rtag, rv, re});
      end
      if (mem_req_valid && mem_req_ready) begin
        if (addr_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL rand unexpected issue: got addr 0x%08h required no request", mem_addr);
        end else chk("rand mem_addr", mem_addr, addr_q.pop_front());
        rsp_active = 1;
        rsp_cnt = $urandom_range(0, 3);
        rsp_addr = mem_addr;
      end
      if (cdb_req && cdb_grant) begin
        if (res_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL rand unexpected retire: got tag %0d required no broadcast", cdb_out_tag);
        end else begin
          er = res_q.pop_front();
          chk("rand cdb tag", 32'(cdb_out_tag), 32'(er.tag));
          chk("rand cdb val", cdb_out_val, er.val);
          chk("rand cdb exc", 32'(cdb_out_exc), 32'(er.exc));
        end
      end
      if (!gen && res_q.size() == 0 && !pend_active && !rsp_active) break;
    end
    idle();
    chk("rand drain", 32'(res_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
